// File: rtl/counter_ctrl_if.sv
// Control strobes and status bundle between software-facing logic and counter_ctrl.
// master drives the strobes and captured inputs; slave is the controller side.
interface counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             pause;
    logic             abort;
    logic             mode_auto;
    logic             dir_up;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             done;
    logic             tc;

    modport master (
        output start, pause, abort, mode_auto, dir_up, load_val,
        input  count, busy, paused, done, tc
    );

    modport slave (
        input  start, pause, abort, mode_auto, dir_up, load_val,
        output count, busy, paused, done, tc
    );
endinterface

// File: rtl/counter_ctrl.sv
// Programmable one-shot / auto-reload up/down timer around a WIDTH-bit count register.
// Optional tick prescaler enabled by defining COUNTER_CTRL_PRESCALE_EN.
module counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input logic           clk,
    input logic           rst,
    counter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_load, w_load_nxt;
    logic             r_dir_up, w_dir_up_nxt;
    logic             r_auto, w_auto_nxt;
    logic             r_tc, w_tc_nxt;
    logic [WIDTH-1:0] w_start_val, w_end_val, w_in_start_val;
    logic             w_tick;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_ctrl: PRESCALE must be at least 1");
    end

    assign w_start_val    = r_dir_up ? '0 : r_load;
    assign w_end_val      = r_dir_up ? r_load : '0;
    assign w_in_start_val = bus.dir_up ? '0 : bus.load_val;

`ifdef COUNTER_CTRL_PRESCALE_EN
    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_presc, w_presc_nxt;

    assign w_tick = (r_presc == PRESC_LAST);
`else
    assign w_tick = 1'b1;
`endif

    // NOTE: every next-state variable gets its default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_load_nxt   = r_load;
        w_dir_up_nxt = r_dir_up;
        w_auto_nxt   = r_auto;
        w_tc_nxt     = 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        w_presc_nxt  = r_presc;
`endif
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
            w_presc_nxt = '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_load_nxt   = bus.load_val;
                        w_dir_up_nxt = bus.dir_up;
                        w_auto_nxt   = bus.mode_auto;
                        w_count_nxt  = w_in_start_val;
                        w_state_nxt  = ST_RUN;
`ifdef COUNTER_CTRL_PRESCALE_EN
                        w_presc_nxt  = '0;
`endif
                    end
                end
                ST_RUN: begin
                    // A tick coinciding with pause entry is dropped and the prescaler holds.
                    if (bus.pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else begin
`ifdef COUNTER_CTRL_PRESCALE_EN
                        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
`endif
                        if (w_tick) begin
                            if (r_count == w_end_val) begin
                                w_tc_nxt = 1'b1;
                                if (r_auto) w_count_nxt = w_start_val;
                                else        w_state_nxt = ST_DONE;
                            end else if (r_dir_up) begin
                                w_count_nxt = r_count + WIDTH'(1);
                            end else begin
                                w_count_nxt = r_count - WIDTH'(1);
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause) w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_load   <= '0;
            r_dir_up <= 1'b0;
            r_auto   <= 1'b0;
            r_tc     <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
            r_presc  <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_load   <= w_load_nxt;
            r_dir_up <= w_dir_up_nxt;
            r_auto   <= w_auto_nxt;
            r_tc     <= w_tc_nxt;
`ifdef COUNTER_CTRL_PRESCALE_EN
            r_presc  <= w_presc_nxt;
`endif
        end
    end

    assign bus.count  = r_count;
    assign bus.busy   = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign bus.paused = (r_state == ST_PAUSE);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.tc     = r_tc;
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: hand-computed outputs checked one cycle at a time.
// Default build covers the unscaled schedule; COUNTER_CTRL_PRESCALE_EN runs the PRESCALE=4 case.
module tb_counter_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    counter_ctrl_if #(.WIDTH(4)) bus ();

    counter_ctrl #(.WIDTH(4), .PRESCALE(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input int cnt, input bit b, input bit p,
                        input bit d, input bit t);
        check({tag, ".count"},  {28'd0, bus.count}, cnt);
        check({tag, ".busy"},   {31'd0, bus.busy},  {31'd0, b});
        check({tag, ".paused"}, {31'd0, bus.paused}, {31'd0, p});
        check({tag, ".done"},   {31'd0, bus.done},  {31'd0, d});
        check({tag, ".tc"},     {31'd0, bus.tc},    {31'd0, t});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int lv, input bit up, input bit auto_m);
        bus.start     = 1'b1;
        bus.load_val  = 4'(lv);
        bus.dir_up    = up;
        bus.mode_auto = auto_m;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.abort     = 1'b0;
        bus.mode_auto = 1'b0;
        bus.dir_up    = 1'b0;
        bus.load_val  = '0;
        #2;
        outs("reset", 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b1;
        outs("idle_after_reset", 0, 0, 0, 0, 0);

`ifdef COUNTER_CTRL_PRESCALE_EN
        // PRESCALE=4, load 1 up one-shot: count steps every 4 cycles, done 9 edges after start.
        launch(1, 1'b1, 1'b0);
        step();
        outs("ps_start", 0, 1, 0, 0, 0);
        bus.start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            outs($sformatf("ps_run%0d", i), (i >= 4) ? 1 : 0, 1, 0, 0, 0);
        end
        step();
        outs("ps_done", 1, 0, 0, 1, 1);
        step();
        outs("ps_idle", 1, 0, 0, 0, 0);
`else
        // One-shot up, load 3; mid-run input changes and a held start must not disturb it.
        launch(3, 1'b1, 1'b0);
        step();
        outs("os_start", 0, 1, 0, 0, 0);
        launch(9, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            outs($sformatf("os_cnt%0d", i), i, 1, 0, 0, 0);
        end
        step();
        outs("os_terminal", 3, 0, 0, 1, 1);
        step();
        outs("os_idle_hold", 3, 0, 0, 0, 0);
        step();
        outs("held_start_relaunch", 9, 1, 0, 0, 0);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        step();
        outs("abort_run", 0, 0, 0, 0, 0);
        bus.abort = 1'b0;

        // Auto-reload down, load 2: 2,1,0,2,1,0,2 with tc on each reload, never done.
        launch(2, 1'b0, 1'b1);
        step();
        outs("ar_start", 2, 1, 0, 0, 0);
        bus.start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            outs($sformatf("ar_cyc%0d", i), (i % 3 == 1) ? 1 : (i % 3 == 2) ? 0 : 2,
                 1, 0, 0, (i % 3 == 0));
        end
        bus.abort = 1'b1;
        step();
        outs("ar_abort", 0, 0, 0, 0, 0);
        bus.abort = 1'b0;

        // Abort coinciding with the terminal tick suppresses tc and done.
        launch(1, 1'b1, 1'b0);
        step();
        bus.start = 1'b0;
        step();
        outs("at_pre", 1, 1, 0, 0, 0);
        bus.abort = 1'b1;
        step();
        outs("at_abort", 0, 0, 0, 0, 0);
        bus.abort = 1'b0;
        step();
        outs("at_after", 0, 0, 0, 0, 0);

        // Start and abort together in IDLE stays IDLE.
        launch(5, 1'b1, 1'b0);
        bus.abort = 1'b1;
        step();
        outs("start_abort", 0, 0, 0, 0, 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // load 0: terminal on the first tick.
        launch(0, 1'b1, 1'b0);
        step();
        outs("z_start", 0, 1, 0, 0, 0);
        bus.start = 1'b0;
        step();
        outs("z_done", 0, 0, 0, 1, 1);
        step();
        outs("z_idle", 0, 0, 0, 0, 0);

        // Pause sampled high on 4 edges at count 4: entry drops a tick, release does not tick.
        launch(9, 1'b1, 1'b0);
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            outs($sformatf("p_cnt%0d", i), i, 1, 0, 0, 0);
        end
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            outs($sformatf("p_hold%0d", i), 4, 1, 1, 0, 0);
        end
        bus.pause = 1'b0;
        step();
        outs("p_release", 4, 1, 0, 0, 0);
        for (int i = 5; i <= 9; i++) begin
            step();
            outs($sformatf("p_cnt%0d", i), i, 1, 0, 0, 0);
        end
        step();
        outs("p_done", 9, 0, 0, 1, 1);
        step();
        outs("p_idle", 9, 0, 0, 0, 0);

        // Asynchronous reset mid-run at count 2, then a normal start afterwards.
        launch(5, 1'b1, 1'b0);
        step();
        bus.start = 1'b0;
        step();
        step();
        outs("r_pre", 2, 1, 0, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        outs("r_async", 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b1;
        launch(1, 1'b1, 1'b0);
        step();
        outs("r_restart", 0, 1, 0, 0, 0);
        bus.start = 1'b0;
        step();
        outs("r_cnt1", 1, 1, 0, 0, 0);
        step();
        outs("r_done", 1, 0, 0, 1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
